// File: rtl/id_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard/redirect controller.
// Holds the controller FSM state type, the stall-need encoding, the
// irq/exception vectors used by the PC mux, and the source-match helper.
package id_hazard_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  // Number of stall cycles the ID instruction requires.
  typedef enum logic [1:0] {
    NEED_NONE = 2'd0,
    NEED_ONE  = 2'd1,
    NEED_TWO  = 2'd2
  } need_e;

  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

  // A source hits a stage when it is really read, is not the hardwired
  // zero register, and equals a destination that the stage will write.
  function automatic logic src_match(
    input logic       use_src,
    input logic [4:0] src,
    input logic [4:0] zero_reg,
    input logic [4:0] rd,
    input logic       reg_write
  );
    return use_src & (src != zero_reg) & (src == rd) & reg_write;
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the decode-stage hazard
// controller.
//   master : pipeline side, drives ID/EX/MEM status, receives controls
//   slave  : controller side
// Status: id_rs/id_rt/id_use_*, id_cmp, id_redirect, id_bad_op, kernel, irq,
//         ex_rd/ex_reg_write/ex_mem_read, mem_rd/mem_reg_write/mem_mem_read
// Controls: pc_write, if_id_write, if_id_flush, id_ex_flush, fwd_rs, fwd_rt,
//           irq_take, exc_take, stall_count
interface id_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_cmp;
  logic             id_redirect;
  logic             id_bad_op;
  logic             kernel;
  logic             irq;
  logic [4:0]       ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [4:0]       mem_rd;
  logic             mem_reg_write;
  logic             mem_mem_read;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             fwd_rs;
  logic             fwd_rt;
  logic             irq_take;
  logic             exc_take;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_cmp, id_redirect,
           id_bad_op, kernel, irq, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, mem_mem_read,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, fwd_rs, fwd_rt,
           irq_take, exc_take, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_cmp, id_redirect,
           id_bad_op, kernel, irq, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, mem_mem_read,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, fwd_rs, fwd_rt,
           irq_take, exc_take, stall_count
  );
endinterface

// File: rtl/id_hazard_ctrl_hazard_match.sv
// Combinational compare of the ID sources against the EX and MEM
// destinations.
// Inputs : ID sources/use bits/id_cmp, EX and MEM rd/reg_write/mem_read
// Outputs: need   - stall cycles required by the ID instruction
//          fwd_rs - compare operand 1 comes from the EX/MEM ALU result
//          fwd_rt - compare operand 2 comes from the EX/MEM ALU result
module hazard_match
  import id_hazard_ctrl_pkg::*;
#(
  parameter logic [4:0] ZERO_REG = 5'd0
) (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_cmp,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic       mem_mem_read,
  output need_e      need,
  output logic       fwd_rs,
  output logic       fwd_rt
);

  logic ex_rs_s;
  logic ex_rt_s;
  logic mem_rs_s;
  logic mem_rt_s;
  logic ex_load_s;
  logic ex_alu_s;
  logic mem_load_s;

  // Per-operand stage hits and the stall-need / forward decode.
  always_comb begin
    ex_rs_s    = src_match(id_use_rs, id_rs, ZERO_REG, ex_rd, ex_reg_write);
    ex_rt_s    = src_match(id_use_rt, id_rt, ZERO_REG, ex_rd, ex_reg_write);
    mem_rs_s   = src_match(id_use_rs, id_rs, ZERO_REG, mem_rd, mem_reg_write);
    mem_rt_s   = src_match(id_use_rt, id_rt, ZERO_REG, mem_rd, mem_reg_write);
    ex_load_s  = (ex_rs_s | ex_rt_s) & ex_mem_read;
    ex_alu_s   = (ex_rs_s | ex_rt_s) & ~ex_mem_read;
    mem_load_s = (mem_rs_s | mem_rt_s) & mem_mem_read;

    // A compare on a load still in EX must wait until the data leaves MEM.
    if (id_cmp & ex_load_s) begin
      need = NEED_TWO;
    end else if (ex_load_s | (id_cmp & ex_alu_s) | (id_cmp & mem_load_s)) begin
      need = NEED_ONE;
    end else begin
      need = NEED_NONE;
    end

    // Only an ALU result sitting in EX/MEM can feed the ID compare.
    fwd_rs = id_cmp & mem_rs_s & ~mem_mem_read;
    fwd_rt = id_cmp & mem_rt_s & ~mem_mem_read;
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard and redirect controller.
// Ports: clk, reset (synchronous, active high), bus (slave side of
//        id_hazard_ctrl_if carrying pipeline status in and controls out).
// Sequences 1/2-cycle stalls, drives ID compare forwarding, PC and IF/ID
// enables, pipeline flushes, irq/exception redirects and a saturating
// stall-cycle counter. Priority: exception > stall > irq > redirect.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter logic [4:0] ZERO_REG = 5'd0
) (
  input logic             clk,
  input logic             reset,
  id_hazard_ctrl_if.slave bus
);

  state_e           state_r;
  logic [1:0]       cnt_r;
  logic             irq_pend_r;
  logic             dslot_r;
  logic [CNT_W-1:0] stall_count_r;

  need_e            need_s;
  logic             fwd_rs_s;
  logic             fwd_rt_s;
  logic             exc_s;
  logic             stall_s;
  logic             irq_take_s;
  logic             redirect_s;
  logic             pc_write_s;
  logic             if_id_write_s;
  logic             if_id_flush_s;
  logic             id_ex_flush_s;

  hazard_match #(
    .ZERO_REG (ZERO_REG)
  ) u_match (
    .id_rs         (bus.id_rs),
    .id_rt         (bus.id_rt),
    .id_use_rs     (bus.id_use_rs),
    .id_use_rt     (bus.id_use_rt),
    .id_cmp        (bus.id_cmp),
    .ex_rd         (bus.ex_rd),
    .ex_reg_write  (bus.ex_reg_write),
    .ex_mem_read   (bus.ex_mem_read),
    .mem_rd        (bus.mem_rd),
    .mem_reg_write (bus.mem_reg_write),
    .mem_mem_read  (bus.mem_mem_read),
    .need          (need_s),
    .fwd_rs        (fwd_rs_s),
    .fwd_rt        (fwd_rt_s)
  );

  // Arbitration of exception, stall, irq and redirect into pipeline controls.
  always_comb begin
    exc_s = bus.id_bad_op & ~reset;

    // Inside STALL the remaining cycles are committed; hazards are not re-read.
    if (reset | exc_s) begin
      stall_s = 1'b0;
    end else if (state_r == STALL) begin
      stall_s = 1'b1;
    end else begin
      stall_s = (need_s != NEED_NONE);
    end

    irq_take_s = ~reset & irq_pend_r & (state_r == RUN) & (need_s == NEED_NONE)
               & ~dslot_r & ~exc_s;
    redirect_s = ~reset & bus.id_redirect & ~stall_s & ~exc_s & ~irq_take_s;

    pc_write_s    = 1'b1;
    if_id_write_s = 1'b1;
    if_id_flush_s = 1'b0;
    id_ex_flush_s = 1'b0;
    if (exc_s) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else if (stall_s) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      id_ex_flush_s = 1'b1;
    end else if (irq_take_s) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else if (redirect_s) begin
      if_id_flush_s = 1'b1;
    end else begin
      if_id_flush_s = 1'b0;
    end
  end

  // Stall sequencer: RUN handles single stalls in place, STALL holds the
  // second cycle of a compare-after-load stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
      cnt_r   <= 2'd0;
    end else if (exc_s) begin
      state_r <= RUN;
      cnt_r   <= 2'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (need_s == NEED_TWO) begin
            state_r <= STALL;
            cnt_r   <= 2'd1;
          end else begin
            state_r <= RUN;
            cnt_r   <= 2'd0;
          end
        end
        STALL: begin
          cnt_r <= cnt_r - 2'd1;
          if (cnt_r <= 2'd1) begin
            state_r <= RUN;
          end else begin
            state_r <= STALL;
          end
        end
        default: begin
          state_r <= RUN;
          cnt_r   <= 2'd0;
        end
      endcase
    end
  end

  // Pending-interrupt latch and branch delay-slot marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_pend_r <= 1'b0;
      dslot_r    <= 1'b0;
    end else begin
      if (irq_take_s) begin
        irq_pend_r <= 1'b0;
      end else if (bus.irq & ~bus.kernel) begin
        irq_pend_r <= 1'b1;
      end else begin
        irq_pend_r <= irq_pend_r;
      end
      dslot_r <= redirect_s;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
      stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign bus.pc_write    = pc_write_s;
  assign bus.if_id_write = if_id_write_s;
  assign bus.if_id_flush = if_id_flush_s;
  assign bus.id_ex_flush = id_ex_flush_s;
  assign bus.fwd_rs      = fwd_rs_s & ~reset;
  assign bus.fwd_rt      = fwd_rt_s & ~reset;
  assign bus.irq_take    = irq_take_s;
  assign bus.exc_take    = exc_s;
  assign bus.stall_count = stall_count_r;

endmodule
